// File: rtl/pb_io_responder.sv
// PicoBlaze I/O bus responder: register bank (receive FIFO, interval timer,
// GPIO) at ram_sel=0 and a 128-byte scratch RAM at ram_sel=1.
// CPU read data is registered, so data_in follows port_id by one clock.
module pb_io_responder #(
   parameter int FIFO_DEPTH = 16,
   parameter int PRESCALE   = 100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] port_id,
   input  logic       ram_sel,
   input  logic [7:0] data_out,
   input  logic       write_strobe,
   input  logic       read_strobe,
   output logic [7:0] data_in,
   output logic       interrupt,
   input  logic       interrupt_ack,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   input  logic [7:0] gpio_in,
   output logic [7:0] gpio_out
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] fifo_cnt, fifo_cnt_next;
   logic          overflow;
   logic [2:0]    control, control_next;
   logic [7:0]    reload, count;
   logic          timer_pending, pending_next;
   logic [PW-1:0] presc;
   logic [7:0]    gpio_s1, gpio_s2;
   logic [7:0]    ram [128];
   logic [7:0]    reg_rd;

   logic reg_wr, ram_wr, fifo_empty, fifo_full, pop, push, drop;
   logic en_rise, tick, timer_evt, irq_clr_wr, irq_next;

   // Bus decode, FIFO push/pop qualification, timer tick and next-state terms
   always_comb begin
      reg_wr       = write_strobe & ~ram_sel;
      ram_wr       = write_strobe & ram_sel;
      fifo_empty   = (fifo_cnt == '0);
      fifo_full    = (fifo_cnt == CW'(FIFO_DEPTH));
      pop          = read_strobe & ~ram_sel & (port_id == 7'h01) & ~fifo_empty;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      push         = rx_valid & (~fifo_full | pop);
      drop         = rx_valid & ~push;
      en_rise      = reg_wr & (port_id == 7'h02) & data_out[0] & ~control[0];
      tick         = control[0] & (presc == PW'(PRESCALE - 1));
      timer_evt    = tick & (count == 8'h00);
      irq_clr_wr   = reg_wr & (port_id == 7'h07);
      // A timer event beats a simultaneous ack or IRQ_CLR.
      pending_next = timer_evt |
                     (timer_pending & ~(interrupt_ack | (irq_clr_wr & data_out[0])));
      control_next = (reg_wr && port_id == 7'h02) ? data_out[2:0] : control;
      fifo_cnt_next = fifo_cnt;
      case ({push, pop})
         2'b10:   fifo_cnt_next = fifo_cnt + CW'(1);
         2'b01:   fifo_cnt_next = fifo_cnt - CW'(1);
         default: fifo_cnt_next = fifo_cnt;
      endcase
      irq_next = (pending_next & control_next[1]) |
                 ((fifo_cnt_next != '0) & control_next[2]);
   end

   // Register-bank read mux
   always_comb begin
      reg_rd = 8'h00;
      case (port_id)
         7'h00:   reg_rd = {4'b0, overflow, timer_pending, fifo_full, fifo_empty};
         7'h01:   reg_rd = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
         7'h02:   reg_rd = {5'b0, control};
         7'h03:   reg_rd = reload;
         7'h04:   reg_rd = count;
         7'h05:   reg_rd = gpio_out;
         7'h06:   reg_rd = gpio_s2;
         default: reg_rd = 8'h00;
      endcase
   end

   // Scratch RAM write port; contents survive reset but writes during reset are dropped
   always_ff @(posedge clk) begin
      if (ram_wr && !reset) ram[port_id] <= data_out;
   end

   // FIFO storage; only the slot being written changes
   always_ff @(posedge clk) begin
      if (push && !reset) fifo_mem[wr_ptr] <= rx_data;
   end

   // Control state, FIFO pointers, timer, interrupt and registered read data
   always_ff @(posedge clk) begin
      if (reset) begin
         data_in       <= 8'h00;
         interrupt     <= 1'b0;
         gpio_out      <= 8'h00;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_cnt      <= '0;
         overflow      <= 1'b0;
         control       <= 3'b000;
         reload        <= 8'hFF;
         count         <= 8'hFF;
         timer_pending <= 1'b0;
         presc         <= '0;
         gpio_s1       <= 8'h00;
         gpio_s2       <= 8'h00;
      end else begin
         data_in       <= ram_sel ? ram[port_id] : reg_rd;
         interrupt     <= irq_next;
         gpio_s1       <= gpio_in;
         gpio_s2       <= gpio_s1;
         fifo_cnt      <= fifo_cnt_next;
         control       <= control_next;
         timer_pending <= pending_next;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         // A dropped byte keeps overflow set even against a same-cycle clear.
         if (drop)                             overflow <= 1'b1;
         else if (irq_clr_wr && data_out[1])   overflow <= 1'b0;
         if (reg_wr && port_id == 7'h03) reload   <= data_out;
         if (reg_wr && port_id == 7'h05) gpio_out <= data_out;
         if (en_rise) begin
            count <= reload;
            presc <= '0;
         end else if (control[0]) begin
            if (tick) begin
               presc <= '0;
               count <= (count == 8'h00) ? reload : count - 8'h01;
            end else begin
               presc <= presc + PW'(1);
            end
         end
      end
   end

endmodule

// File: doc/pb_io_responder.md
Name: pb_io_responder

Overview:
- Peripheral-side responder for the 8-bit PicoBlaze I/O bus: port_id, ram_sel, write_strobe, read_strobe, CPU write data, CPU read data, interrupt and interrupt_ack.
- Decodes CPU INPUT/OUTPUT accesses into two targets:
  - a register bank (ram_sel=0) holding a receive FIFO, an interval timer and GPIO;
  - a 128-byte scratch RAM (ram_sel=1).
- Generates the CPU interrupt and retires it on interrupt_ack.
- Sits beside the processor/program-memory top and connects bus-to-bus.

Parameters:
- FIFO_DEPTH, 16, receive FIFO entries (power of two, 2..64).
- PRESCALE, 100, clk cycles per timer tick (>=1).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- port_id  input  7  CPU port address (low bits).
- ram_sel  input  1  CPU port_id[7]; 1 selects scratch RAM, 0 selects the register bank.
- data_out  input  8  CPU write data, valid with write_strobe.
- write_strobe  input  1  CPU OUTPUT strobe, one cycle.
- read_strobe  input  1  CPU INPUT strobe, one cycle.
- data_in  output  8  CPU read data, registered.
- interrupt  output  1  CPU interrupt request, registered.
- interrupt_ack  input  1  CPU interrupt acknowledge pulse.
- rx_valid  input  1  external byte-present strobe for the FIFO.
- rx_data  input  8  external byte.
- gpio_in  input  8  asynchronous inputs.
- gpio_out  output  8  GPIO_OUT register.

Behaviour:
- Reset values:
  - data_in=0x00, interrupt=0, gpio_out=0x00.
  - FIFO empty; overflow=0; CONTROL=0x00; RELOAD=0xFF; COUNT=0xFF; timer_pending=0; prescaler=0.
  - RAM contents are not reset.
- Read path: data_in <= decode(ram_sel, port_id) every clk, giving 1-cycle latency from port_id. This meets the PicoBlaze input timing.
  - The RAM read is synchronous and uses the same 1-cycle latency.
- Register map (ram_sel=0):
  - 0x00 STATUS, RO: {4'b0, overflow, timer_pending, full, empty}.
  - 0x01 FIFO_DATA, RO: current head byte, or 0x00 when empty. read_strobe at 0x01 pops one entry if non-empty; reading an empty FIFO has no effect.
  - 0x02 CONTROL, RW: bit0 timer_en, bit1 timer_irq_en, bit2 fifo_irq_en; bits 7:3 read 0.
  - 0x03 RELOAD, RW.
  - 0x04 COUNT, RO.
  - 0x05 GPIO_OUT, RW.
  - 0x06 GPIO_IN, RO: gpio_in through a 2-flop synchroniser.
  - 0x07 IRQ_CLR, WO: bit0=1 clears timer_pending; bit1=1 clears overflow. Reads return 0x00.
  - All other addresses read 0x00; writes to them are ignored.
- Writes: on write_strobe, data_out is captured at the decoded target in the same edge. With ram_sel=1, ram[port_id] <= data_out.
- FIFO:
  - Circular buffer with wrap-around read/write pointers and a count.
  - rx_valid pushes rx_data if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set (sticky until cleared via IRQ_CLR).
  - A simultaneous push and pop leaves count unchanged.
  - Pushing while empty: the new head is visible on data_in 2 cycles after rx_valid.
- Timer:
  - When a CONTROL write sets timer_en 0->1, COUNT <= RELOAD and the prescaler clears.
  - While timer_en=1, the prescaler counts 0..PRESCALE-1; a tick occurs at PRESCALE-1.
  - On a tick: if COUNT==0, then COUNT <= RELOAD and timer_pending <= 1; else COUNT <= COUNT-1.
  - timer_en=0 freezes COUNT and the prescaler.
  - RELOAD=0 gives a pending event every tick.
- Interrupt:
  - interrupt <= (timer_pending_next & timer_irq_en) | (!empty_next & fifo_irq_en).
  - interrupt_ack clears timer_pending. If a timer event lands in the same cycle as the ack, the event wins and pending stays 1.
  - The FIFO source is level-based: it stays asserted until the FIFO is drained or fifo_irq_en is cleared.
  - IRQ_CLR has the same priority rule as the ack: a simultaneous timer event wins.
- Reset asserted mid-operation: every state returns to its reset value on that edge; any write or pop in that cycle is discarded.

Test Plan:
- Reset, then read ports 0x00/0x03/0x04 -> data_in 0x01, 0xFF, 0xFF one cycle after port_id; interrupt=0.
- Write 0xA5 to RAM 0x7F (ram_sel=1), write 0x3C to GPIO_OUT, read both back -> 0xA5, gpio_out=0x3C; reading ram_sel=0 port 0x7F -> 0x00.
- Push 17 bytes 0x10..0x20 with FIFO_DEPTH=16 -> STATUS=0x0A (full+overflow); 16 popped reads return 0x10..0x1F, then STATUS=0x09; write IRQ_CLR=0x02 -> STATUS=0x01.
- Full FIFO, rx_valid coincident with a pop -> byte accepted, overflow stays 0, count stays 16; ordering preserved across pointer wrap.
- PRESCALE=4, RELOAD=2, CONTROL=0x03 -> interrupt rises at 12 clks + 1 register cycle after the enable write; interrupt_ack -> interrupt low next cycle; repeats every 12 clks.
- fifo_irq_en=1, push one byte -> interrupt high; interrupt_ack alone keeps it high; popping the byte -> interrupt low the following cycle.
